bus_dev_port: RTL
=================

# bus_dev_port

Device-side endpoint of the broadcast/arbitrated packet bus: one instance per bus device, attached to one `[bits][drvrs]` slot of the bus generator/arbiter. It buffers host packets in a TX FIFO, presents them to the bus through `pndng`/`D_pop`/`pop`, and accepts bus deliveries through `push`/`D_push` into an RX FIFO drained by the host. This is the synthesizable counterpart of the behavioural driver/monitor used in the bus benches.

## Interface
- `pckg_sz`, 16: packet width in bits; `[pckg_sz-1 -: 8]` is the destination ID, the rest is payload; legal range ≥ 9.
- `depth`, 8: entries per FIFO; power of two, 2..256.
- `id`, 0: this device's 8-bit bus ID.
- `broadcast`, 8'hFF: destination ID accepted by every device.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `pndng`  out  1  TX FIFO non-empty; bus side.
- `D_pop`  out  pckg_sz  TX FIFO head (show-ahead); bus side.
- `pop`  in  1  bus consumes the TX head this cycle.
- `push`  in  1  bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  delivered packet.
- `tx_wr`  in  1  host write strobe.
- `tx_data`  in  pckg_sz  host packet.
- `tx_full`  out  1  TX FIFO holds `depth` entries.
- `rx_vld`  out  1  RX FIFO non-empty.
- `rx_data`  out  pckg_sz  RX FIFO head (show-ahead).
- `rx_rd`  in  1  host consumes the RX head.
- `drop_cnt`  out  8  saturating count of discarded deliveries.
- `err`  out  2  sticky: [0] pop while empty, [1] tx_wr while full.

## Operation
- TX FIFO: `tx_wr && !tx_full` enqueues `tx_data`. `tx_wr` while full is ignored, even when `pop` is asserted in the same cycle, and sets `err[1]`.
- `pop && pndng` dequeues. `pop` while empty is ignored and sets `err[0]`.
- RX FIFO: `push` with an accepted packet (see Configuration) enqueues `D_push` if not full. If the RX FIFO is full, the packet is dropped even if `rx_rd` is asserted in the same cycle, and `drop_cnt` increments.
- `rx_rd && rx_vld` dequeues. `rx_rd` while empty is ignored with no flag.
- Simultaneous enqueue and dequeue on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Pointers are `$clog2(depth)` bits and wrap modulo `depth`. Count is `$clog2(depth)+1` bits.
- `drop_cnt` saturates at 8'hFF. `err` bits clear only on `reset`.
- Reset values: `pndng`=0, `tx_full`=0, `rx_vld`=0, `drop_cnt`=0, `err`=0. `D_pop` and `rx_data` are 0 after reset; after reset they track the FIFO head, and their value is don't-care while the FIFO is empty.
- Reset mid-operation empties both FIFOs on the next edge; any same-cycle `tx_wr`, `push`, `pop` or `rx_rd` is discarded.

## Timing
- `tx_wr` at edge N → `pndng`=1 and `D_pop` valid after edge N (one-cycle latency).
- `pop` at edge N → the next head appears on `D_pop` after edge N; `pndng` falls after edge N if the FIFO becomes empty.
- `push` at edge N → `rx_vld`/`rx_data` valid after edge N.
- `tx_full` and `rx_vld` are registered-count decodes; no combinational path from any input to any output.
- Throughput: one enqueue and one dequeue per FIFO per cycle.

## Configuration
- `BUS_DEV_FILTER_EN` defined: a delivery is accepted only if `D_push[pckg_sz-1 -: 8]` equals `id` or `broadcast`. Any other delivery is discarded and counted in `drop_cnt`.
- `BUS_DEV_FILTER_EN` undefined: every `push` is accepted, and `drop_cnt` counts only overflow drops.

## Test plan
- Reset, then write 16'h0155 and 16'h03AA → `pndng`=1 one cycle after the first write; `D_pop`=16'h0155; after a `pop`, `D_pop`=16'h03AA; after a second `pop`, `pndng`=0.
- Fill TX with `depth`=8 writes, then a ninth write with `pop` asserted in the same cycle → `tx_full`=1, ninth write lost, `err[1]`=1, count 7 after the edge.
- With `id`=2 and the filter enabled, push 16'h0211, 16'hFF22 and 16'h0533 → RX holds 16'h0211 and 16'hFF22, `drop_cnt`=1. With the filter disabled → all three accepted, `drop_cnt`=0.
- Fill RX with 8 pushes, push 300 more with no reads → `drop_cnt` saturates at 8'hFF; `rx_data` still equals the first packet.
- Keep both FIFOs half full with simultaneous push/read and wr/pop for 20 cycles → data order preserved across pointer wrap; counts constant.
- Assert `reset` with 3 TX and 2 RX entries plus a concurrent `tx_wr` → `pndng`=0, `rx_vld`=0, `err`=0 and `drop_cnt`=0 on the next cycle.

Source files
------------

// File: rtl/bus_dev_port.sv
// Device-side bus endpoint: host TX FIFO toward the bus, bus RX FIFO toward the host.
// Optional destination filtering on deliveries when BUS_DEV_FILTER_EN is defined.

module bus_dev_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         nempty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          enq, deq;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign nempty = (cnt_q != '0);
    assign rdata  = mem_q[rptr_q];
    assign enq    = wr && !full;
    assign deq    = rd && nempty;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (enq) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + AW'(1);
        end
        if (deq) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage is cleared on reset so the show-ahead head reads 0 afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module bus_dev_port #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               rx_vld,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd,
    output logic [7:0]         drop_cnt,
    output logic [1:0]         err
);
`ifdef BUS_DEV_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic       rx_full;
    logic       dest_hit, accept, rx_wr, drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [1:0] err_q, err_d;

    assign dest_hit = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
    assign accept   = FILTER_EN ? dest_hit : 1'b1;
    assign rx_wr    = push && accept;
    assign drop     = push && (!accept || rx_full);

    bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx (
        .clk    (clk),
        .reset  (reset),
        .wr     (tx_wr),
        .wdata  (tx_data),
        .rd     (pop),
        .rdata  (D_pop),
        .full   (tx_full),
        .nempty (pndng)
    );

    bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_wr),
        .wdata  (D_push),
        .rd     (rx_rd),
        .rdata  (rx_data),
        .full   (rx_full),
        .nempty (rx_vld)
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        err_d      = err_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (pop && !pndng) begin
            err_d[0] = 1'b1;
        end
        if (tx_wr && tx_full) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err      = err_q;
endmodule
